mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single Argon memory port between NREQ requesters (req 0 = core, req 1 = debug/DMA).
//  Arbitrates, registers the winning request and drives the memory bus for MEM_LAT cycles.
//  Captures read data and returns it with a one-cycle valid pulse to the winner.
//  Sits between the requesters and the memory; the memory itself is unchanged.
// PARAMETERS
//  NREQ     2   number of requesters, 2..4
//  MEM_LAT  1   cycles from address/masks driven to i_mem_rd_data valid, 1..7
// PORTS
//  i_clk          in   1          system clock
//  i_reset_n      in   1          asynchronous, active-low reset
//  i_req          in   NREQ       request, level; held until o_gnt
//  i_lock         in   NREQ       keep grant for the next request of the same requester
//  i_addr         in   NREQ*32    byte address per requester
//  i_wr_data      in   NREQ*32    write data per requester
//  i_rd_mask      in   NREQ*3     read mask (RDMASK_*), 0 = no read
//  i_wr_mask      in   NREQ*2     write mask (WRMASK_*), 0 = no write
//  o_gnt          out  NREQ       one-hot 1-cycle pulse: request accepted, payload sampled
//  o_rvalid       out  NREQ       one-hot 1-cycle pulse: access complete
//  o_rd_data      out  32         read data, valid with o_rvalid (shared by all requesters)
//  o_mem_addr     out  32         memory address
//  o_mem_wr_data  out  32         memory write data
//  o_mem_rd_mask  out  3          memory read mask
//  o_mem_wr_mask  out  2          memory write mask
//  i_mem_rd_data  in   32         memory read data
// BEHAVIOUR
//  Reset: state IDLE, o_gnt/o_rvalid/o_rd_data/o_mem_* = 0, priority pointer = 0, lock owner cleared.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE:   on an edge with any i_req high, pick the winner, pulse o_gnt[w] for the next cycle,
//            register addr/data/masks, enter ACCESS. With no request, stay in IDLE.
//  - ACCESS: drive o_mem_* from the registered payload; a counter runs MEM_LAT cycles,
//            then the state moves to DONE.
//  - DONE:   o_rd_data <= i_mem_rd_data if rd_mask != 0, else 0; pulse o_rvalid[w];
//            return o_mem_* masks to 0; go to IDLE.
//  Latency: request sampled at edge t; o_gnt high in cycle t+1; bus driven cycles t+1..t+MEM_LAT;
//    o_rvalid high in cycle t+MEM_LAT+1. Throughput: one access per MEM_LAT+2 cycles.
//  Outside ACCESS, o_mem_rd_mask and o_mem_wr_mask are 0. o_mem_addr and o_mem_wr_data hold their last value.
//  Lock: if i_lock[w] is high when o_gnt[w] fires, w owns the port. The next IDLE grants only w
//    while i_req[w] is high. Ownership releases on the first grant with i_lock[w] low, or when IDLE
//    sees i_req[w] low.
//  rd_mask != 0 and wr_mask != 0 both set: the access is a write; o_rd_data = 0.
//  Both masks 0: the access is a no-op. It is still granted and completes with o_rvalid; the bus masks stay 0.
//  A requester dropping i_req before o_gnt: the request is withdrawn; no grant is issued for it.
//  Reset asserted mid-access: the access is abandoned immediately and no o_rvalid is issued.
//  o_gnt and o_rvalid are never high for more than one requester, and never high in the same cycle.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: rotating priority. After a grant to w, highest priority goes to (w+1) mod NREQ.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; the pointer is unused.
//  Lock semantics are identical in both modes.
// STRUCTURE
//  Package argon_mem_pkg holds:
//  - RDMASK_NONE/B/H/W and WRMASK_NONE/B/H/W constants
//  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_DONE}
//  - typedef struct mem_req_t {addr, wr_data, rd_mask, wr_mask}
//  Sub-module arb_rr_picker: combinational one-hot winner from req, pointer, lock owner.
//  The FSM, payload registers and latency counter stay in mem_port_arbiter.
// TESTING
//  1. Single read: req0 addr 0x100, rd_mask=W; mem returns 0xDEADBEEF
//     -> gnt0 at t+1, o_mem_addr=0x100 with rd_mask W for MEM_LAT cycles,
//        rvalid0 at t+MEM_LAT+1 with o_rd_data=0xDEADBEEF.
//  2. Contention, RR build: req0 and req1 held continuously for 4 accesses
//     -> grants 0,1,0,1. Fixed-priority build -> grants 0,0,0,0.
//  3. Lock: req1 with lock=1 for 3 accesses while req0 is held -> grants 1,1,1, then 0 after lock drops.
//  4. Write: req1 addr 0x20, wr_data 0x55AA, wr_mask=W, rd_mask=W
//     -> o_mem_wr_mask=W and o_mem_rd_mask=0 during ACCESS; rvalid1 with o_rd_data=0.
//  5. Reset mid-access: i_reset_n low in the 2nd ACCESS cycle (MEM_LAT=3)
//     -> all outputs 0 immediately; no rvalid; first request after release granted normally.
//  6. Withdraw: req0 high then low before its arbitration edge -> no gnt0, bus masks stay 0.

Source files
------------

// File: rtl/argon_mem_pkg.sv
// Shared constants and types for the Argon memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package argon_mem_pkg;

    localparam logic [2:0] RDMASK_NONE = 3'd0;
    localparam logic [2:0] RDMASK_B    = 3'd1;
    localparam logic [2:0] RDMASK_H    = 3'd2;
    localparam logic [2:0] RDMASK_W    = 3'd3;

    localparam logic [1:0] WRMASK_NONE = 2'd0;
    localparam logic [1:0] WRMASK_B    = 2'd1;
    localparam logic [1:0] WRMASK_H    = 2'd2;
    localparam logic [1:0] WRMASK_W    = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic [2:0]  rd_mask;
        logic [1:0]  wr_mask;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundle of the Argon memory port arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are level-held until the arbiter pulses o_gnt.
interface mem_port_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]       i_req;
    logic [NREQ-1:0]       i_lock;
    logic [NREQ-1:0][31:0] i_addr;
    logic [NREQ-1:0][31:0] i_wr_data;
    logic [NREQ-1:0][2:0]  i_rd_mask;
    logic [NREQ-1:0][1:0]  i_wr_mask;
    logic [NREQ-1:0]       o_gnt;
    logic [NREQ-1:0]       o_rvalid;
    logic [31:0]           o_rd_data;
    logic [31:0]           o_mem_addr;
    logic [31:0]           o_mem_wr_data;
    logic [2:0]            o_mem_rd_mask;
    logic [1:0]            o_mem_wr_mask;
    logic [31:0]           i_mem_rd_data;

    // arbiter view
    modport slave (
        input  i_req, i_lock, i_addr, i_wr_data, i_rd_mask, i_wr_mask, i_mem_rd_data,
        output o_gnt, o_rvalid, o_rd_data, o_mem_addr, o_mem_wr_data, o_mem_rd_mask, o_mem_wr_mask
    );

    // requester/memory view
    modport master (
        output i_req, i_lock, i_addr, i_wr_data, i_rd_mask, i_wr_mask, i_mem_rd_data,
        input  o_gnt, o_rvalid, o_rd_data, o_mem_addr, o_mem_wr_data, o_mem_rd_mask, o_mem_wr_mask
    );
endinterface

// File: rtl/arb_rr_picker.sv
// One-hot winner selection: lock owner first, else first request searching upward from ptr.
// Latency: combinational.
// Backpressure: none; a zero ptr gives plain lowest-index-wins priority.
module arb_rr_picker #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            lock_vld,
    input  logic [PW-1:0]   lock_owner,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx,
    output logic            win_any
);
    int          idx;
    logic [PW-1:0] idx_v;

    // locked owner preempts everyone while it still requests; otherwise rotate from ptr
    always_comb begin
        win     = '0;
        win_idx = '0;
        win_any = 1'b0;
        idx     = 0;
        idx_v   = '0;
        if (lock_vld && req[lock_owner]) begin
            win[lock_owner] = 1'b1;
            win_idx         = lock_owner;
            win_any         = 1'b1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                idx   = (int'(ptr) + i) % NREQ;
                idx_v = PW'(idx);
                if (!win_any && req[idx_v]) begin
                    win[idx_v] = 1'b1;
                    win_idx    = idx_v;
                    win_any    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NREQ requesters; ARB_ROUND_ROBIN_EN selects rotating priority.
// Latency: gnt one cycle after the sampled request, rvalid MEM_LAT+1 cycles after it.
// Backpressure: requests wait (level-held) while an access is in flight; one access per MEM_LAT+2 cycles.
module mem_port_arbiter
    import argon_mem_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MEM_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    arb_state_t      state;
    logic [2:0]      lat_cnt;
    mem_req_t        req_q;
    mem_req_t        sel;
    logic [PW-1:0]   win_q;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   lock_owner;
    logic            lock_vld;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;
    logic            win_any;

    arb_rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req        (bus.i_req),
        .ptr        (ptr),
        .lock_vld   (lock_vld),
        .lock_owner (lock_owner),
        .win        (win_oh),
        .win_idx    (win_idx),
        .win_any    (win_any)
    );

    // winner's payload; a write mask turns the access into a pure write
    always_comb begin
        sel         = '0;
        sel.addr    = bus.i_addr[win_idx];
        sel.wr_data = bus.i_wr_data[win_idx];
        sel.wr_mask = bus.i_wr_mask[win_idx];
        sel.rd_mask = (bus.i_wr_mask[win_idx] != WRMASK_NONE) ? RDMASK_NONE : bus.i_rd_mask[win_idx];
    end

`ifdef ARB_ROUND_ROBIN_EN
    // after each grant the next requester up gets top priority
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr <= '0;
        end else if (state == ARB_IDLE && win_any) begin
            ptr <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    // arbitration FSM, payload capture, latency count and response pulse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ARB_IDLE;
            lat_cnt       <= '0;
            req_q         <= '0;
            win_q         <= '0;
            lock_vld      <= 1'b0;
            lock_owner    <= '0;
            bus.o_gnt     <= '0;
            bus.o_rvalid  <= '0;
            bus.o_rd_data <= '0;
        end else begin
            bus.o_gnt    <= '0;
            bus.o_rvalid <= '0;
            case (state)
                ARB_IDLE: begin
                    // owner stopped requesting: give the port back before arbitrating
                    if (lock_vld && !bus.i_req[lock_owner]) begin
                        lock_vld <= 1'b0;
                    end
                    if (win_any) begin
                        bus.o_gnt  <= win_oh;
                        win_q      <= win_idx;
                        req_q      <= sel;
                        lat_cnt    <= '0;
                        lock_vld   <= bus.i_lock[win_idx];
                        lock_owner <= win_idx;
                        state      <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (lat_cnt == LAT_LAST) begin
                        bus.o_rvalid  <= {{(NREQ-1){1'b0}}, 1'b1} << win_q;
                        bus.o_rd_data <= (req_q.rd_mask != RDMASK_NONE) ? bus.i_mem_rd_data : 32'd0;
                        state         <= ARB_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                ARB_DONE: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // bus masks only live during ACCESS; address and data simply hold
    assign bus.o_mem_addr    = req_q.addr;
    assign bus.o_mem_wr_data = req_q.wr_data;
    assign bus.o_mem_rd_mask = (state == ARB_ACCESS) ? req_q.rd_mask : RDMASK_NONE;
    assign bus.o_mem_wr_mask = (state == ARB_ACCESS) ? req_q.wr_mask : WRMASK_NONE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with NREQ=2, MEM_LAT=3.
// Latency: gnt at t+1, bus t+1..t+3, rvalid at t+4.
// Backpressure: requests held until gnt is seen.
module tb_mem_port_arbiter;
    import argon_mem_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.NREQ(2)) bus ();

    mem_port_arbiter #(.NREQ(2), .MEM_LAT(3)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // wait (bounded) for a grant, check winner and address, then wait for its completion
    task automatic access(input logic [1:0] eg, input logic [31:0] ea, input logic [31:0] erd, input string tag);
        int k;
        k = 0;
        do begin
            tick;
            k++;
        end while (bus.o_gnt == 2'b00 && k < 20);
        chk({tag, "_gnt"}, 32'(bus.o_gnt), 32'(eg));
        chk({tag, "_addr"}, bus.o_mem_addr, ea);
        k = 0;
        do begin
            tick;
            k++;
        end while (bus.o_rvalid == 2'b00 && k < 20);
        chk({tag, "_rvalid"}, 32'(bus.o_rvalid), 32'(eg));
        chk({tag, "_rdata"}, bus.o_rd_data, erd);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_req = '0;
        bus.i_lock = '0;
        bus.i_addr = '0;
        bus.i_wr_data = '0;
        bus.i_rd_mask = '0;
        bus.i_wr_mask = '0;
        bus.i_mem_rd_data = '0;

        // reset state
        repeat (2) tick;
        chk("rst_gnt", 32'(bus.o_gnt), 32'd0);
        chk("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
        chk("rst_rdata", bus.o_rd_data, 32'd0);
        chk("rst_addr", bus.o_mem_addr, 32'd0);
        chk("rst_wdata", bus.o_mem_wr_data, 32'd0);
        chk("rst_masks", 32'({bus.o_mem_rd_mask, bus.o_mem_wr_mask}), 32'd0);
        rst_n = 1'b1;
        tick;

        // single read from requester 0
        bus.i_req = 2'b01;
        bus.i_addr[0] = 32'h100;
        bus.i_rd_mask[0] = RDMASK_W;
        bus.i_mem_rd_data = 32'h12345678;
        tick;
        chk("rd_gnt_t1", 32'(bus.o_gnt), 32'd1);
        chk("rd_addr_t1", bus.o_mem_addr, 32'h100);
        chk("rd_mask_t1", 32'(bus.o_mem_rd_mask), 32'(RDMASK_W));
        chk("rd_rvalid_t1", 32'(bus.o_rvalid), 32'd0);
        bus.i_req = 2'b00;
        tick;
        chk("rd_gnt_t2", 32'(bus.o_gnt), 32'd0);
        chk("rd_mask_t2", 32'(bus.o_mem_rd_mask), 32'(RDMASK_W));
        tick;
        chk("rd_mask_t3", 32'(bus.o_mem_rd_mask), 32'(RDMASK_W));
        chk("rd_rvalid_t3", 32'(bus.o_rvalid), 32'd0);
        bus.i_mem_rd_data = 32'hDEADBEEF;
        tick;
        chk("rd_rvalid_t4", 32'(bus.o_rvalid), 32'd1);
        chk("rd_rdata_t4", bus.o_rd_data, 32'hDEADBEEF);
        chk("rd_mask_t4", 32'(bus.o_mem_rd_mask), 32'd0);
        bus.i_mem_rd_data = 32'h12345678;
        tick;
        chk("rd_rvalid_t5", 32'(bus.o_rvalid), 32'd0);

        // no-op from requester 1: granted and completed, masks stay 0
        bus.i_req = 2'b10;
        bus.i_addr[1] = 32'h40;
        tick;
        chk("nop_gnt", 32'(bus.o_gnt), 32'd2);
        chk("nop_addr", bus.o_mem_addr, 32'h40);
        chk("nop_masks_t1", 32'({bus.o_mem_rd_mask, bus.o_mem_wr_mask}), 32'd0);
        bus.i_req = 2'b00;
        repeat (2) tick;
        chk("nop_masks_t3", 32'({bus.o_mem_rd_mask, bus.o_mem_wr_mask}), 32'd0);
        tick;
        chk("nop_rvalid", 32'(bus.o_rvalid), 32'd2);
        chk("nop_rdata", bus.o_rd_data, 32'd0);
        tick;

        // write with both masks set from requester 1
        bus.i_req = 2'b10;
        bus.i_addr[1] = 32'h20;
        bus.i_wr_data[1] = 32'h55AA;
        bus.i_wr_mask[1] = WRMASK_W;
        bus.i_rd_mask[1] = RDMASK_W;
        bus.i_mem_rd_data = 32'hFFFFFFFF;
        tick;
        chk("wr_gnt", 32'(bus.o_gnt), 32'd2);
        chk("wr_addr", bus.o_mem_addr, 32'h20);
        chk("wr_wdata", bus.o_mem_wr_data, 32'h55AA);
        chk("wr_wmask_t1", 32'(bus.o_mem_wr_mask), 32'(WRMASK_W));
        chk("wr_rmask_t1", 32'(bus.o_mem_rd_mask), 32'd0);
        bus.i_req = 2'b00;
        repeat (2) tick;
        chk("wr_wmask_t3", 32'(bus.o_mem_wr_mask), 32'(WRMASK_W));
        tick;
        chk("wr_rvalid", 32'(bus.o_rvalid), 32'd2);
        chk("wr_rdata", bus.o_rd_data, 32'd0);
        chk("wr_wmask_t4", 32'(bus.o_mem_wr_mask), 32'd0);
        tick;

        // contention: both requesters held for four accesses
        bus.i_addr[0] = 32'h1000;
        bus.i_addr[1] = 32'h2000;
        bus.i_rd_mask[0] = RDMASK_W;
        bus.i_rd_mask[1] = RDMASK_W;
        bus.i_wr_mask = '0;
        bus.i_mem_rd_data = 32'h0BADF00D;
        bus.i_req = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
        access(2'b01, 32'h1000, 32'h0BADF00D, "cont0");
        access(2'b10, 32'h2000, 32'h0BADF00D, "cont1");
        access(2'b01, 32'h1000, 32'h0BADF00D, "cont2");
        access(2'b10, 32'h2000, 32'h0BADF00D, "cont3");
`else
        access(2'b01, 32'h1000, 32'h0BADF00D, "cont0");
        access(2'b01, 32'h1000, 32'h0BADF00D, "cont1");
        access(2'b01, 32'h1000, 32'h0BADF00D, "cont2");
        access(2'b01, 32'h1000, 32'h0BADF00D, "cont3");
`endif
        bus.i_req = 2'b00;
        tick;

        // lock: requester 1 keeps the port while requester 0 waits
        bus.i_req = 2'b10;
        bus.i_lock = 2'b10;
        access(2'b10, 32'h2000, 32'h0BADF00D, "lock0");
        bus.i_req = 2'b11;
        access(2'b10, 32'h2000, 32'h0BADF00D, "lock1");
        access(2'b10, 32'h2000, 32'h0BADF00D, "lock2");
        bus.i_req = 2'b01;
        bus.i_lock = 2'b00;
        access(2'b01, 32'h1000, 32'h0BADF00D, "lock3");
        bus.i_req = 2'b00;
        tick;

        // reset in the second ACCESS cycle
        bus.i_addr[0] = 32'h300;
        bus.i_req = 2'b01;
        tick;
        chk("rstm_gnt", 32'(bus.o_gnt), 32'd1);
        bus.i_req = 2'b00;
        tick;
        rst_n = 1'b0;
        #1;
        chk("rstm_rdata", bus.o_rd_data, 32'd0);
        chk("rstm_addr", bus.o_mem_addr, 32'd0);
        chk("rstm_masks", 32'({bus.o_mem_rd_mask, bus.o_mem_wr_mask}), 32'd0);
        chk("rstm_pulses", 32'({bus.o_gnt, bus.o_rvalid}), 32'd0);
        tick;
        chk("rstm_rvalid_a", 32'(bus.o_rvalid), 32'd0);
        tick;
        chk("rstm_rvalid_b", 32'(bus.o_rvalid), 32'd0);
        rst_n = 1'b1;
        bus.i_addr[0] = 32'h400;
        bus.i_mem_rd_data = 32'hCAFEF00D;
        bus.i_req = 2'b01;
        tick;
        chk("post_gnt", 32'(bus.o_gnt), 32'd1);
        chk("post_addr", bus.o_mem_addr, 32'h400);
        bus.i_req = 2'b00;
        repeat (2) tick;
        chk("post_rvalid_early", 32'(bus.o_rvalid), 32'd0);
        tick;
        chk("post_rvalid", 32'(bus.o_rvalid), 32'd1);
        chk("post_rdata", bus.o_rd_data, 32'hCAFEF00D);
        tick;

        // withdrawn request: raised and dropped between edges
        bus.i_addr[0] = 32'h500;
        bus.i_req = 2'b01;
        #2;
        bus.i_req = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("wd_gnt", 32'(bus.o_gnt), 32'd0);
            chk("wd_rmask", 32'(bus.o_mem_rd_mask), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
